// File: rtl/vadd_pkg.sv
// Shared definitions for the vadd stream stages.
//
// ap_ctrl_hs signal-bundle contract (all signals on ap_clk, synchronous):
//   ap_start  in   request; a block samples it only while IDLE
//   ap_idle   out  high while IDLE and ap_start is low
//   ap_done   out  one-cycle pulse once the block's work is complete
//   ap_ready  out  one-cycle pulse, coincident with ap_done
package vadd_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 10;

    // One-hot control states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register FIFO with a registered head.
// Ports: clk, rst (sync, active-high), push/din write side, pop read side,
//        head = oldest entry, count = occupancy 0..2.
// The producer must not push while count==2 unless it also pops.
module skid_buf2 #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] tail;
    logic         do_pop;

    // A pop on an empty buffer is ignored.
    assign do_pop = pop & (count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            unique case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vadd_load_stream.sv
// Stream-load stage: on an ap_ctrl_hs start, reads len words from a
// 1-cycle-latency memory starting at base_addr and writes them in address
// order into a stream FIFO, honouring back-pressure at up to one word/cycle.
// Ports: ap_clk/ap_rst (sync, active-high); ap_start/ap_done/ap_idle/ap_ready
//        control; base_addr/len job; mem_address/mem_ce/mem_q memory read;
//        s_V_din/s_V_full_n/s_V_write stream write.
module vadd_load_stream
    import vadd_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_ce,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] s_V_din,
    input  logic              s_V_full_n,
    output logic              s_V_write
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  len_r;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  written;
    logic [CNT_W-1:0]  written_nxt;
    logic              inflight;
    logic [1:0]        buf_cnt;
    logic              pop;
    logic [2:0]        occ;

    // Words the buffer will hold once the read in flight lands.
    assign pop         = s_V_write & s_V_full_n;
    assign occ         = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
    assign written_nxt = written + CNT_W'(pop);

    assign mem_ce      = (state == ST_RUN) && (issued < len_r) && (occ < 3'd2);
    assign mem_address = base_r + issued[ADDR_W-1:0];
    assign s_V_write   = (buf_cnt != 2'd0);
    assign ap_done     = (state == ST_DONE);
    assign ap_ready    = (state == ST_DONE);
    assign ap_idle     = (state == ST_IDLE) && !ap_start;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (ap_start) state_nxt = (len != '0) ? ST_RUN : ST_DONE;
            ST_RUN:  if ((written_nxt == len_r) && !inflight) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, job latch, counters and in-flight flag.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= ST_IDLE;
            base_r   <= '0;
            len_r    <= '0;
            issued   <= '0;
            written  <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= mem_ce;
            if ((state == ST_IDLE) && ap_start) begin
                base_r  <= base_addr;
                len_r   <= CNT_W'(len);
                issued  <= '0;
                written <= '0;
            end else begin
                if (mem_ce) issued  <= issued + CNT_W'(1);
                if (pop)    written <= written_nxt;
            end
        end
    end

    // Read data is captured the cycle after mem_ce; reset drops any pending read.
    skid_buf2 #(
        .W (DATA_W)
    ) u_buf (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .push  (inflight),
        .din   (mem_q),
        .pop   (pop),
        .head  (s_V_din),
        .count (buf_cnt)
    );

endmodule

// File: tb/tb_vadd_load_stream.sv
module tb_vadd_load_stream;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          ap_start = 1'b0;
    logic          ap_done, ap_idle, ap_ready;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len = '0;
    logic [AW-1:0] mem_address;
    logic          mem_ce;
    logic [DW-1:0] mem_q = '0;
    logic [DW-1:0] s_V_din;
    logic          s_V_full_n = 1'b1;
    logic          s_V_write;

    vadd_load_stream #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .base_addr   (base_addr),
        .len         (len),
        .mem_address (mem_address),
        .mem_ce      (mem_ce),
        .mem_q       (mem_q),
        .s_V_din     (s_V_din),
        .s_V_full_n  (s_V_full_n),
        .s_V_write   (s_V_write)
    );

    always #5 ap_clk = ~ap_clk;

    // Memory model and random back-pressure source.
    logic [DW-1:0] mem [1024];
    bit            rnd_full = 1'b0;
    int            cyc = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;
    always @(posedge ap_clk) if (mem_ce) mem_q <= mem[mem_address];
    always @(posedge ap_clk) begin
        #1;
        s_V_full_n = rnd_full ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: observed traffic, relative to the start cycle.
    logic [DW-1:0] got_q[$];
    logic [AW-1:0] addr_q[$];
    int            gotc_q[$];
    int            done_q[$];
    int            n_rd, n_wr, max_out, pulse_bad, start_cyc;

    always @(negedge ap_clk) begin
        if (mem_ce) begin
            n_rd++;
            addr_q.push_back(mem_address);
        end
        if (s_V_write && s_V_full_n) begin
            got_q.push_back(s_V_din);
            gotc_q.push_back(cyc - start_cyc);
            n_wr++;
        end
        if (n_rd - n_wr > max_out) max_out = n_rd - n_wr;
        if (ap_done) done_q.push_back(cyc - start_cyc);
        if (ap_done != ap_ready) pulse_bad++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic fill_mem(input bit rnd);
        for (int a = 0; a < 1024; a++) mem[a] = rnd ? $urandom : 32'(a * 3);
    endtask

    task automatic clear_mon();
        got_q.delete(); addr_q.delete(); gotc_q.delete(); done_q.delete();
        n_rd = 0; n_wr = 0; max_out = 0; pulse_bad = 0;
        start_cyc = cyc;
    endtask

    // Start sampled in the current cycle (cycle 0); job inputs scrambled afterwards.
    task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] l);
        clear_mon();
        base_addr = b;
        len       = l;
        ap_start  = 1'b1;
        tick();
        ap_start  = 1'b0;
        base_addr = AW'($urandom);
        len       = AW'($urandom);
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_q.size() >= n), 32'd1);
    endtask

    // Reference: the stream must equal mem[base..base+len-1] with address wrap.
    task automatic check_stream(input string tag, input logic [AW-1:0] b, input int l);
        logic [AW-1:0] a;
        chk({tag, "_nwords"}, 32'(got_q.size()), 32'(l));
        chk({tag, "_nreads"}, 32'(n_rd), 32'(l));
        for (int i = 0; i < l && i < got_q.size(); i++) begin
            a = b + AW'(i);
            chk({tag, "_word"}, got_q[i], mem[a]);
        end
        chk({tag, "_credit"}, 32'(max_out <= 2), 32'd1);
        chk({tag, "_ready_eq_done"}, 32'(pulse_bad), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"}, 32'(ap_done), 32'd0);
        chk({tag, "_ready"}, 32'(ap_ready), 32'd0);
        chk({tag, "_ce"}, 32'(mem_ce), 32'd0);
        chk({tag, "_write"}, 32'(s_V_write), 32'd0);
        chk({tag, "_addr"}, 32'(mem_address), 32'd0);
        chk({tag, "_din"}, s_V_din, 32'd0);
        chk({tag, "_idle"}, 32'(ap_idle), 32'd1);
    endtask

    initial begin
        logic [AW-1:0] b;
        int            l;

        fill_mem(1'b0);
        clear_mon();
        repeat (3) tick();
        ap_rst = 1'b0;
        chk_reset_outputs("rst");

        // Test 1: fixed pattern, exact latency.
        tick();
        start_run(10'h010, 10'd4);
        wait_done("t1", 1, 50);
        check_stream("t1", 10'h010, 4);
        for (int i = 0; i < 4 && i < gotc_q.size(); i++)
            chk("t1_write_cycle", 32'(gotc_q[i]), 32'(3 + i));
        if (done_q.size() > 0) chk("t1_done_cycle", 32'(done_q[0]), 32'd7);
        chk("t1_idle_after", 32'(ap_idle), 32'd1);

        // Test 2: zero length.
        tick();
        start_run(10'h123, 10'd0);
        wait_done("t2", 1, 20);
        repeat (4) tick();
        if (done_q.size() > 0) chk("t2_done_cycle", 32'(done_q[0]), 32'd1);
        chk("t2_ndone", 32'(done_q.size()), 32'd1);
        chk("t2_nreads", 32'(n_rd), 32'd0);
        chk("t2_nwrites", 32'(n_wr), 32'd0);
        chk("t2_ready_eq_done", 32'(pulse_bad), 32'd0);

        // Test 3: random back-pressure, len=8 then random jobs.
        rnd_full = 1'b1;
        for (int it = 0; it < 8; it++) begin
            fill_mem(1'b1);
            b = AW'($urandom);
            l = (it == 0) ? 8 : $urandom_range(1, 24);
            tick();
            start_run(b, AW'(l));
            wait_done("t3", 1, 2000);
            check_stream("t3", b, l);
        end
        rnd_full = 1'b0;
        tick();

        // Test 4: address wrap at the top of memory.
        fill_mem(1'b1);
        tick();
        start_run(10'h3FE, 10'd4);
        wait_done("t4", 1, 50);
        check_stream("t4", 10'h3FE, 4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
            b = 10'h3FE + AW'(i);
            chk("t4_addr", 32'(addr_q[i]), 32'(b));
        end

        // Test 5: reset in the middle of a run, then a clean short run.
        tick();
        start_run(10'h040, 10'd16);
        repeat (3) tick();
        ap_rst = 1'b1;
        tick();
        chk_reset_outputs("t5_rst");
        ap_rst = 1'b0;
        repeat (2) tick();
        start_run(10'h200, 10'd2);
        wait_done("t5", 1, 50);
        repeat (6) tick();
        check_stream("t5", 10'h200, 2);
        chk("t5_ndone", 32'(done_q.size()), 32'd1);

        // Test 6: ap_start held across two back-to-back runs.
        tick();
        clear_mon();
        base_addr = 10'h080;
        len       = 10'd3;
        ap_start  = 1'b1;
        repeat (9) tick();
        ap_start  = 1'b0;
        wait_done("t6", 2, 60);
        repeat (4) tick();
        chk("t6_ndone", 32'(done_q.size()), 32'd2);
        if (done_q.size() >= 2) begin
            chk("t6_done0_cycle", 32'(done_q[0]), 32'd6);
            chk("t6_done1_cycle", 32'(done_q[1]), 32'd13);
        end
        chk("t6_nwords", 32'(got_q.size()), 32'd6);
        chk("t6_nreads", 32'(n_rd), 32'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            b = 10'h080 + AW'(i % 3);
            chk("t6_word", got_q[i], mem[b]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
